// File: rtl/ifetch.sv
// rtl/ifetch.sv - single-outstanding instruction fetch stage between PC register and decode
module ifetch #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic        pc_valid,
  output logic        pc_accept,
  input  logic        flush,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_misalign,
  input  logic        dec_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q;
  logic [63:0] req_pc_q;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;
  logic        misalign_q;
  logic        pc_misaligned;

  // Misalignment is only meaningful when the check is enabled
  assign pc_misaligned = CHECK_ALIGN && (pc[1:0] != 2'b00);

  // The PC register advances only when a fresh fetch can start
  assign pc_accept = (state_q == IDLE) && pc_valid && !flush;

  // Bus request stays up (DISCARD included) until its single response returns
  assign ireq_valid    = (state_q == REQ) || (state_q == DISCARD);
  assign ireq_addr     = req_pc_q;
  assign inst_valid    = (state_q == HOLD);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_misalign = misalign_q;

  // Fetch FSM with the request address and held instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_pc_q   <= 64'd0;
      inst_q     <= 32'd0;
      inst_pc_q  <= 64'd0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_accept) begin
            if (pc_misaligned) begin
              // Report the exception straight to decode; the bus never sees it
              inst_q     <= 32'd0;
              inst_pc_q  <= pc;
              misalign_q <= 1'b1;
              state_q    <= HOLD;
            end else begin
              req_pc_q <= pc;
              state_q  <= REQ;
            end
          end
        end
        REQ: begin
          if (iresp_data_ok) begin
            if (flush) begin
              state_q <= IDLE;
            end else begin
              inst_q     <= iresp_data;
              inst_pc_q  <= req_pc_q;
              misalign_q <= 1'b0;
              state_q    <= HOLD;
            end
          end else if (flush) begin
            // Response still owed by the bus; wait it out and drop it
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          if (iresp_data_ok) begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (dec_ready || flush) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
